// File: rtl/memory_access_responder_pkg.sv
// Shared types for the load/store responder: request modes, FSM states,
// RV32I width codes and a legality check for the funct3 field.
package JZJCoreFTypes;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MemoryMode_t;

  typedef enum logic [2:0] {
    MA_IDLE,
    MA_READ,
    MA_EXTRACT,
    MA_MERGE,
    MA_WRITE,
    MA_DONE,
    MA_ERROR
  } MemAccessState_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(
    input MemoryMode_t mode,
    input logic [2:0]  f3
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (f3 == F3_B), (f3 == F3_H), (f3 == F3_W): ok = 1'b1;
      (f3 == F3_BU), (f3 == F3_HU): ok = (mode == MEM_LOAD);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/memory_byte_lane_unit.sv
// Byte/half lane steering: extends the addressed lane of a RAM word for loads
// and splices store data into the addressed lane for sub-word stores.
module memory_byte_lane_unit
  import JZJCoreFTypes::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] storeData,
  output logic [31:0] load_word,
  output logic [31:0] store_word
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shamt   = {addr, 3'b000};
  assign shifted = ram_rdata >> shamt;
  assign byte_v  = shifted[7:0];
  assign half_v  = addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  always_comb begin
    load_word = ram_rdata;
    unique case (1'b1)
      (funct3 == F3_B):  load_word = {{24{byte_v[7]}}, byte_v};
      (funct3 == F3_BU): load_word = {24'h0, byte_v};
      (funct3 == F3_H):  load_word = {{16{half_v[15]}}, half_v};
      (funct3 == F3_HU): load_word = {16'h0, half_v};
      default:           load_word = ram_rdata;
    endcase
  end

  always_comb begin
    store_word = storeData;
    unique case (1'b1)
      (funct3 == F3_B):
        store_word = (ram_rdata & ~(32'h0000_00FF << shamt))
                   | ({24'h0, storeData[7:0]} << shamt);
      (funct3 == F3_H):
        store_word = addr[1]
          ? {storeData[15:0], ram_rdata[15:0]}
          : {ram_rdata[31:16], storeData[15:0]};
      default:
        store_word = storeData;
    endcase
  end

endmodule

// File: rtl/memory_access_responder.sv
// Load/store responder on a word-wide single-port RAM without byte enables.
// Ports: clock/reset, request bundle in, loadData + status out, RAM side.
module memory_access_responder
  import JZJCoreFTypes::*;
#(
  parameter int          RAM_WORDS  = 4096,
  parameter logic [31:0] RESET_LOAD = 32'h0,
  localparam int         AW         = $clog2(RAM_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          memoryRequest,
  input  MemoryMode_t   memoryMode,
  input  logic [2:0]    funct3,
  input  logic [31:0]   address,
  input  logic [31:0]   storeData,
  output logic [31:0]   loadData,
  output logic          memoryBusy,
  output logic          memoryDone,
  output logic          memoryUnalignedAccess,
  output logic          memoryBadFunct3,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic          ram_we,
  input  logic [31:0]   ram_rdata
);

  MemAccessState_t state, state_nx;
  MemoryMode_t     mode_q;
  logic [2:0]      f3_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     sdata_q;

  logic        accept;
  logic        bad_f3;
  logic        misal;
  logic [31:0] load_word;
  logic [31:0] store_word;
  logic        unused_addr;

  // Address bits above the RAM depth are dropped: accesses wrap.
  assign unused_addr = ^address[31:AW+2];

  assign accept = memoryRequest
               && (state == MA_IDLE)
               && (memoryMode != MEM_NOP);

  // Bad funct3 takes precedence; alignment is judged only for legal widths.
  assign bad_f3 = !f3_legal(memoryMode, funct3);

  always_comb begin
    misal = 1'b0;
    unique case (1'b1)
      (funct3[1:0] == 2'b01): misal = address[0];
      (funct3[1:0] == 2'b10): misal = |address[1:0];
      default:                misal = 1'b0;
    endcase
    if (bad_f3) misal = 1'b0;
  end

  memory_byte_lane_unit u_lane (
    .funct3     (f3_q),
    .addr       (addr_q[1:0]),
    .ram_rdata  (ram_rdata),
    .storeData  (sdata_q),
    .load_word  (load_word),
    .store_word (store_word)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= MA_IDLE;
      mode_q  <= MEM_NOP;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      sdata_q <= 32'h0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mode_q  <= memoryMode;
        f3_q    <= funct3;
        addr_q  <= address[AW+1:0];
        sdata_q <= storeData;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      loadData              <= RESET_LOAD;
      memoryUnalignedAccess <= 1'b0;
      memoryBadFunct3       <= 1'b0;
    end else begin
      if (state == MA_EXTRACT) loadData <= load_word;
      if (accept && bad_f3) memoryBadFunct3 <= 1'b1;
      if (accept && misal) memoryUnalignedAccess <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      MA_IDLE: begin
        if (accept) begin
          if (bad_f3 || misal)
            state_nx = MA_ERROR;
          else if (memoryMode == MEM_STORE && funct3 == F3_W)
            state_nx = MA_WRITE;
          else
            state_nx = MA_READ;
        end
      end
      MA_READ:
        state_nx = (mode_q == MEM_LOAD) ? MA_EXTRACT : MA_MERGE;
      MA_EXTRACT: state_nx = MA_DONE;
      MA_MERGE:   state_nx = MA_DONE;
      MA_WRITE:   state_nx = MA_DONE;
      MA_DONE:    state_nx = MA_IDLE;
      MA_ERROR:   state_nx = MA_ERROR;
      default:    state_nx = MA_IDLE;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = 32'h0;
    unique case (state)
      MA_WRITE: begin
        ram_we    = 1'b1;
        ram_wdata = sdata_q;
      end
      MA_MERGE: begin
        ram_we    = 1'b1;
        ram_wdata = store_word;
      end
      default: begin
        ram_we    = 1'b0;
        ram_wdata = 32'h0;
      end
    endcase
  end

  assign ram_addr   = addr_q[AW+1:2];
  assign memoryBusy = (state != MA_IDLE);
  assign memoryDone = (state == MA_DONE);

endmodule
